// File: rtl/bcd_chain_ctrl_if.sv
// bcd_chain_ctrl_if: control-plane / display-side bundle for bcd_chain_ctrl.
//   master : board control FSM drives commands (start/stop/clear/load_en),
//            load_val and target; it observes count/running/done/tick/ovf.
//   slave  : the counter chain sequencer.
//   When BCD_CHAIN_DOWN_EN is defined, the bundle also carries 'down'
//   (count direction, sampled on each tick).
interface bcd_chain_ctrl_if #(parameter int DIGITS = 4);
  logic                  start, stop, clear, load_en;
  logic [4*DIGITS-1:0]   load_val, target, count;
  logic                  running, done, tick, ovf;
`ifdef BCD_CHAIN_DOWN_EN
  logic                  down;
  modport master (output start, stop, clear, load_en, load_val, target, down,
                  input  count, running, done, tick, ovf);
  modport slave  (input  start, stop, clear, load_en, load_val, target, down,
                  output count, running, done, tick, ovf);
`else
  modport master (output start, stop, clear, load_en, load_val, target,
                  input  count, running, done, tick, ovf);
  modport slave  (input  start, stop, clear, load_en, load_val, target,
                  output count, running, done, tick, ovf);
`endif
endinterface

// File: rtl/bcd_chain_ctrl.sv
// bcd_chain_ctrl: sequencer for a chain of DIGITS cascaded mod-10 counters.
//   A prescaler produces one count tick every PRESCALE cycles in RUN; the tick
//   ripples carry through the decades and stops the chain on a BCD target.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : start/stop/clear/load_en pulses, load_val, target in;
//                  count, running, done, tick, ovf out (all registered)
// Optional: define BCD_CHAIN_DOWN_EN to add bus.down (count down when 1).

// One decade: steps up (9->0) or down (0->9) when enabled.
module bcd_chain_digit (
  input  logic [3:0] d_i,
  input  logic       en_i,
  input  logic       dn_i,
  output logic [3:0] d_o
);
  always_comb begin
    d_o = d_i;
    if (en_i) begin
      if (dn_i) d_o = (d_i == 4'd0) ? 4'd9 : d_i - 4'd1;
      else      d_o = (d_i == 4'd9) ? 4'd0 : d_i + 4'd1;
    end
  end
endmodule

module bcd_chain_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  bcd_chain_ctrl_if.slave   bus
);
  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [DIGITS-1:0][3:0] cnt_q, cnt_d, cnt_step, load_clamp;
  logic [PW-1:0]          pre_q, pre_d;
  logic                   tick_q, tick_d, ovf_q, ovf_d;
  logic                   dn;
  logic [DIGITS:0]        en;   // en[k]: decade k steps; en[DIGITS]: chain wraps
  logic                   pre_wrap, match;

`ifdef BCD_CHAIN_DOWN_EN
  assign dn = bus.down;
`else
  assign dn = 1'b0;
`endif

  // A decade steps when every lower decade sits at its terminal digit.
  always_comb begin
    en[0] = 1'b1;
    for (int k = 0; k < DIGITS; k++)
      en[k+1] = en[k] & (dn ? (cnt_q[k] == 4'd0) : (cnt_q[k] == 4'd9));
  end

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_chain_digit u_dig (
        .d_i  (cnt_q[g]),
        .en_i (en[g]),
        .dn_i (dn),
        .d_o  (cnt_step[g])
      );
      assign load_clamp[g] = (bus.load_val[4*g +: 4] > 4'd9) ? 4'd9
                                                             : bus.load_val[4*g +: 4];
    end
  endgenerate

  // cnt_step is always valid BCD, so a target with a digit >9 never matches.
  assign match    = (cnt_step == bus.target);
  assign pre_wrap = (state_q == S_RUN) && (pre_q == PRE_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    ovf_d   = 1'b0;
    if (bus.clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      pre_d   = '0;
    end else begin
      // Tick processing first so that a coincident stop still lands the count.
      if (state_q == S_RUN) begin
        if (pre_wrap) begin
          pre_d  = '0;
          cnt_d  = cnt_step;
          tick_d = 1'b1;
          ovf_d  = en[DIGITS];
          if (match) state_d = S_DONE;
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      // Only the highest-priority asserted command acts.
      if (bus.stop) begin
        if (state_q == S_RUN) state_d = S_PAUSE;
      end else if (bus.load_en) begin
        if (state_q == S_IDLE || state_q == S_PAUSE) begin
          cnt_d = load_clamp;
          pre_d = '0;
        end
      end else if (bus.start) begin
        if (state_q == S_IDLE) pre_d = '0;
        if (state_q != S_RUN)  state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count   = cnt_q;
  assign bus.running = (state_q == S_RUN);
  assign bus.done    = (state_q == S_DONE);
  assign bus.tick    = tick_q;
  assign bus.ovf     = ovf_q;
endmodule

// File: doc/bcd_chain_ctrl.md
Name: bcd_chain_ctrl

Overview:
- Sequencer for a chain of DIGITS cascaded mod-10 digit counters, held internally as one digit register per decade.
- Generates a prescaled count tick and ripples carry between digits.
- Stops on a programmable BCD target and handles start/stop/clear/load commands from the control plane.
- Sits between the board-level control FSM and the seven-segment/display datapath.

Parameters:
DIGITS, 4, number of BCD decades; count width = 4*DIGITS
PRESCALE, 10, clk cycles per count tick; legal range >= 1; PRESCALE=1 means a tick every RUN cycle

Ports:
clk  input  1  clock
reset_n  input  1  reset
start  input  1  pulse; begin/resume counting
stop  input  1  pulse; pause counting
clear  input  1  pulse; zero count, return to IDLE
load_en  input  1  pulse; load load_val into count
load_val  input  4*DIGITS  BCD preset, digit 0 in [3:0]
target  input  4*DIGITS  BCD terminal value, sampled every cycle
count  output  4*DIGITS  current BCD count, registered
running  output  1  high in RUN
done  output  1  high in DONE
tick  output  1  one-cycle pulse on each count update
ovf  output  1  one-cycle pulse when the count wraps from all-9s to all-0s

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Reset values: count=0, prescaler=0, state=IDLE, running=0, done=0, tick=0, ovf=0.
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE --start--> RUN.
  - RUN --stop--> PAUSE.
  - RUN --(tick and new count == target)--> DONE.
  - PAUSE --start--> RUN.
  - DONE --start--> RUN; the count is not cleared first.
  - Any state --clear--> IDLE with count=0.
- Command priority when pulses coincide: clear > stop > load_en > start. Only the highest-priority command acts in that cycle.
- load_en:
  - Accepted only in IDLE or PAUSE; ignored in RUN and DONE.
  - count takes load_val on the next edge.
  - Any load_val digit >9 is clamped to 9.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUN.
  - Holds its value in PAUSE.
  - Resets to 0 on clear, on load, and on entry to RUN from IDLE.
  - Tick condition: prescaler == PRESCALE-1 while in RUN.
- Digit update on a tick:
  - Digit 0 increments.
  - Digit k (k>0) increments only when digits 0..k-1 are all 9.
  - Any digit at 9 that increments goes to 0.
  - All-9s wraps to all-0s and pulses ovf in the same cycle as tick.
- tick and ovf are registered; they go high in the cycle the new count appears.
- Target compare:
  - Uses the post-increment value.
  - done and the DONE state appear in the same cycle as the matching count.
  - A target equal to the count at start is not matched until the count returns to it after a wrap.
  - A target digit >9 never matches.
- stop in the same cycle as a tick: the tick still updates count, then the block enters PAUSE.
- Async reset mid-count: everything returns to reset values immediately. No tick, ovf, or done is emitted on reset release.
- Outputs change only on clk edges; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: BCD_CHAIN_DOWN_EN.
- Defined:
  - Adds input port "down" (1 bit), sampled on each tick.
  - down=1 decrements: digit 0 decrements; digit k decrements only when digits 0..k-1 are all 0; a digit at 0 goes to 9.
  - All-0s wraps to all-9s and pulses ovf.
  - Target compare applies in both directions.
- Undefined: no down port; up-count only.

Test Plan:
- DIGITS=4, PRESCALE=4: reset, then start. Required: tick every 4th cycle; count 0000→0001→0002…; running=1.
- Load 0099 in IDLE, then start. Required: the next tick gives count 0100 in one cycle, with no intermediate 0090/0109.
- Load 9999, start. Required: the next tick gives 0000 and ovf=1 for exactly one cycle; done stays 0 (target=0500).
- target=0012, start from 0000. Required: on the 12th tick count=0012, done=1, running=0; further cycles hold 0012; start resumes counting to 0013.
- stop asserted on the tick cycle at count 0005. Required: count=0006, state PAUSE, prescaler held. load_en with 1A3F gives count 1939. clear together with start gives IDLE with count 0000.
- BCD_CHAIN_DOWN_EN defined, down=1, load 1000, start. Required: the next tick gives 0999. Load 0000, tick: count 9999 with ovf pulse. Drop reset_n mid-RUN: outputs go to zero asynchronously.
